csa_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 32-bit, 8-bit-block combinational carry-select adder.
- Each pipeline stage resolves one BLK-bit segment. Both candidate sums (carry-in 0 and carry-in 1) are computed in that stage, and the registered carry from the previous stage selects between them.
- Valid/ready handshake on both sides, with full backpressure.
- Sits in the datapath wherever a wide add/sub must close timing at high clock rates.

---
 rtl/csa_pipe_adder.sv | 135 +++++++++++++
 tb/tb_csa_pipe_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipe_adder.sv
// rtl/csa_pipe_adder.sv - pipelined carry-select adder/subtractor, one BLK-bit segment per stage
// Optional signed-overflow output enabled by defining CSA_PIPE_OVF_EN.
`timescale 1ns/1ps
module csa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef CSA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG = (BLK < 1) ? 1 : WIDTH / BLK;

  if (BLK < 1 || (WIDTH % ((BLK < 1) ? 1 : BLK)) != 0) begin : g_cfg_err
    $error("csa_pipe_adder: WIDTH must be a positive multiple of BLK");
  end

  logic [NSTG-1:0] v_all;
  logic [NSTG-1:0] adv;

  // Ready ripples back from the output: a stage moves if it is empty or its successor moves.
  always_comb begin
    adv = '0;
    adv[NSTG-1] = !v_all[NSTG-1] || out_ready;
    for (int k = NSTG - 2; k >= 0; k--) begin
      adv[k] = !v_all[k] || adv[k+1];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int W_IN = WIDTH - k * BLK;
    localparam int W_S  = (k + 1) * BLK;

    logic            v_in;
    logic            c_in;
    logic [W_IN-1:0] a_in;
    logic [W_IN-1:0] b_in;
    logic [W_S-1:0]  s_nx;
    logic [BLK:0]    s0;
    logic [BLK:0]    s1;
    logic [BLK:0]    sel;
    logic            v_q;
    logic            c_q;
    logic [W_S-1:0]  s_q;

    if (k == 0) begin : g_src
      assign v_in = in_valid;
      assign a_in = A;
      assign b_in = sub ? ~B : B;
      assign c_in = sub | Cin;
      assign s_nx = sel[BLK-1:0];
    end else begin : g_src
      assign v_in = g_stg[k-1].v_q;
      assign a_in = g_stg[k-1].g_keep.a_q;
      assign b_in = g_stg[k-1].g_keep.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign s_nx = {sel[BLK-1:0], g_stg[k-1].s_q};
    end

    // Both candidates are formed in parallel; the registered carry only drives the final mux.
    assign s0  = {1'b0, a_in[BLK-1:0]} + {1'b0, b_in[BLK-1:0]};
    assign s1  = s0 + (BLK + 1)'(1);
    assign sel = c_in ? s1 : s0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv[k]) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= sel[BLK];
          s_q <= s_nx;
        end
      end
    end

    // Only the operand bits not yet consumed travel further down the pipe.
    if (k < NSTG - 1) begin : g_keep
      logic [W_IN-BLK-1:0] a_q;
      logic [W_IN-BLK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && v_in) begin
          a_q <= a_in[W_IN-1:BLK];
          b_q <= b_in[W_IN-1:BLK];
        end
      end
    end

    assign v_all[k] = v_q;
  end

  assign in_ready  = adv[0];
  assign out_valid = v_all[NSTG-1];
  assign Sum       = g_stg[NSTG-1].s_q;
  assign Cout      = g_stg[NSTG-1].c_q;

`ifdef CSA_PIPE_OVF_EN
  logic ovf_q;
  logic c_msb;

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  assign c_msb = g_stg[NSTG-1].a_in[BLK-1] ^ g_stg[NSTG-1].b_in[BLK-1] ^ g_stg[NSTG-1].sel[BLK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv[NSTG-1] && g_stg[NSTG-1].v_in) begin
      ovf_q <= c_msb ^ g_stg[NSTG-1].sel[BLK];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb/tb_csa_pipe_adder.sv - directed self-checking bench for csa_pipe_adder (32/8, 64/16, 8/8)
`timescale 1ns/1ps
module tb_csa_pipe_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        in_valid = 0, in_ready, Cin = 0, sub = 0, out_valid, out_ready = 1, Cout;
  logic [31:0] A = '0, B = '0, Sum;
  logic        iv64 = 0, ir64, ci64 = 0, sb64 = 0, ov64, co64;
  logic [63:0] a64 = '0, b64 = '0, s64;
  logic        iv8 = 0, ir8, ci8 = 0, sb8 = 0, ov8, co8;
  logic [7:0]  a8 = '0, b8 = '0, s8;
`ifdef CSA_PIPE_OVF_EN
  logic ovf, ovf64, ovf8;
`endif

  csa_pipe_adder #(.WIDTH(32), .BLK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .Cin(Cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout)
`ifdef CSA_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  csa_pipe_adder #(.WIDTH(64), .BLK(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
    .Cin(ci64), .sub(sb64), .out_valid(ov64), .out_ready(1'b1), .Sum(s64), .Cout(co64)
`ifdef CSA_PIPE_OVF_EN
    , .ovf(ovf64)
`endif
  );

  csa_pipe_adder #(.WIDTH(8), .BLK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .Cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(1'b1), .Sum(s8), .Cout(co8)
`ifdef CSA_PIPE_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, b, input logic ci, sb);
    logic [31:0] bb;
    bb = sb ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + 33'(sb | ci);
  endfunction

  task automatic sample(input int w, output logic v, output logic [63:0] s, output logic c, o);
    o = 1'b0;
    case (w)
      64: begin v = ov64; s = s64; c = co64; end
      8:  begin v = ov8;  s = {56'b0, s8}; c = co8; end
      default: begin v = out_valid; s = {32'b0, Sum}; c = Cout; end
    endcase
`ifdef CSA_PIPE_OVF_EN
    o = (w == 64) ? ovf64 : (w == 8) ? ovf8 : ovf;
`endif
  endtask

  task automatic op(input int w, input string tag, input logic [63:0] a, b, input logic ci, sb,
                    input logic [63:0] es, input logic ec, eo, input int lat);
    int n;
    logic v, c, o;
    logic [63:0] s;
    case (w)
      64: begin a64 = a; b64 = b; ci64 = ci; sb64 = sb; iv64 = 1; end
      8:  begin a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; sb8 = sb; iv8 = 1; end
      default: begin
        A = a[31:0]; B = b[31:0]; Cin = ci; sub = sb; in_valid = 1; out_ready = 1;
        check({tag, "_rdy"}, in_ready, 1);
      end
    endcase
    tick();
    in_valid = 0; iv64 = 0; iv8 = 0;
    n = 1;
    sample(w, v, s, c, o);
    while (!v && n < 20) begin
      tick();
      n++;
      sample(w, v, s, c, o);
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_sum"}, s, es);
    check({tag, "_cout"}, c, ec);
`ifdef CSA_PIPE_OVF_EN
    check({tag, "_ovf"}, o, eo);
`else
    if (eo !== o) check({tag, "_ovf_port"}, o, 0);
`endif
  endtask

  logic [32:0] q[$];
  logic [32:0] e;
  int n;

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    tick();
    rst_n = 1;
    check("rst_in_ready", in_ready, 1);

    op(32, "add_ff_1", 64'hFF, 64'h1, 0, 0, 64'h100, 0, 0, 4);
    op(32, "carry_chain", 64'hFFFF_FFFF, 64'h0, 1, 0, 64'h0, 1, 0, 4);
    op(32, "sub_5_7", 64'h5, 64'h7, 0, 1, 64'hFFFF_FFFE, 0, 0, 4);
    op(32, "sub_cin_ign", 64'hA, 64'h3, 1, 1, 64'h7, 1, 0, 4);
    op(32, "sub_0_0", 64'h0, 64'h0, 0, 1, 64'h0, 1, 0, 4);
    op(32, "ovf_pos", 64'h7FFF_FFFF, 64'h1, 0, 0, 64'h8000_0000, 0, 1, 4);
    op(32, "ovf_neg", 64'h8000_0000, 64'h8000_0000, 0, 0, 64'h0, 1, 1, 4);
    op(64, "w64_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 64'h0, 1, 0, 4);
    op(64, "w64_sub", 64'h1_0000_0000, 64'h1, 0, 1, 64'hFFFF_FFFF, 1, 0, 4);
    op(8, "w8_add", 64'hF0, 64'h0F, 1, 0, 64'h00, 1, 0, 1);
    op(8, "w8_sub", 64'h03, 64'h05, 0, 1, 64'hFE, 0, 0, 1);
    op(8, "w8_ovf", 64'h80, 64'h01, 0, 1, 64'h7F, 1, 1, 1);

    // Streaming, one op per cycle with out_ready held high
    out_ready = 1;
    n = 0;
    for (int c = 0; c < 104; c++) begin
      if (c < 100) begin
        A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1;
      end else begin
        in_valid = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) check("stream_extra", 1, 0);
        else begin
          e = q.pop_front();
          check("stream", {Cout, Sum}, e);
        end
        n++;
      end
      if (in_valid && in_ready) q.push_back(model(A, B, Cin, sub));
      tick();
    end
    in_valid = 0;
    check("stream_count", n, 100);
    check("stream_left", q.size(), 0);
    q.delete();

    // Backpressure: fill with out_ready low, then drain
    out_ready = 0;
    for (int c = 0; c < 10; c++) begin
      A = 32'h1000_0000 + c; B = 32'h0100_0000 * c; Cin = c[0]; sub = c[1];
      in_valid = 1;
      check("bp_in_ready", in_ready, q.size() < 4);
      if (out_valid) check("bp_hold", {Cout, Sum}, q[0]);
      if (in_ready) q.push_back(model(A, B, Cin, sub));
      tick();
    end
    in_valid = 0;
    check("bp_full_valid", out_valid, 1);
    out_ready = 1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (q.size() == 0) check("bp_extra", 1, 0);
        else begin
          e = q.pop_front();
          check("bp_drain", {Cout, Sum}, e);
        end
        n++;
      end
      tick();
    end
    check("bp_drain_count", n, 4);
    q.delete();

    // Reset with three ops in flight
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      A = 32'h55 + c; B = 32'h1; Cin = 0; sub = 0; in_valid = 1;
      tick();
    end
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("mid_valid_before_rst", out_valid, 1);
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", Sum, 0);
    tick();
    tick();
    rst_n = 1;
    out_ready = 1;
    check("mid_rst_in_ready", in_ready, 1);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) n++;
      tick();
    end
    check("mid_rst_stale", n, 0);
    op(32, "after_rst", 64'h1234, 64'h1111, 0, 0, 64'h2345, 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
